// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmit frame controller.
// UART_TX_2STOP_EN adds a second stop state (STOP2) to the encoding.
package uart_tx_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_TX_2STOP_EN
  localparam logic [2:0] STOP2  = 3'd5;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = IDLE,
    ST_START  = START,
    ST_DATA   = DATA,
    ST_PARITY = PARITY,
`ifdef UART_TX_2STOP_EN
    ST_STOP   = STOP,
    ST_STOP2  = STOP2
`else
    ST_STOP   = STOP
`endif
  } state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte-side, serializer-side and line signals of the UART transmit controller.
// master = surrounding datapath, slave = the frame controller.
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  SER_DONE;
  logic                  SER_OUT;
  logic                  SER_EN;
  logic                  BUSY;
  logic                  TX_OUT;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, SER_DONE, SER_OUT,
    input  SER_EN, BUSY, TX_OUT
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, SER_DONE, SER_OUT,
    output SER_EN, BUSY, TX_OUT
  );
endinterface

// File: rtl/uart_parity_calc.sv
// Combinational parity of the parallel byte, even or odd per par_typ.
module uart_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  assign par_bit = (par_typ == PAR_ODD) ? ~^data : ^data;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: sequences start/data/parity/stop around an
// external serializer and drives a registered TX line. Optional UART_TX_2STOP_EN.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_ctrl_if.slave  bus
);

  state_e state_q, state_d;
  logic   busy_q, busy_d;
  logic   tx_q, tx_d;
  logic   par_en_q, par_en_d;
  logic   par_bit_q, par_bit_d;
  logic   par_calc;

  uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data    (bus.P_DATA),
    .par_typ (bus.PAR_TYP),
    .par_bit (par_calc)
  );

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.DATA_VALID) begin
          state_d   = ST_START;
          par_en_d  = bus.PAR_EN;
          // Parity type is folded into the captured parity bit here.
          par_bit_d = par_calc;
        end
      end
      ST_START:  state_d = ST_DATA;
      ST_DATA: begin
        if (bus.SER_DONE) state_d = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: state_d = ST_STOP;
`ifdef UART_TX_2STOP_EN
      ST_STOP:   state_d = ST_STOP2;
      ST_STOP2:  state_d = ST_IDLE;
`else
      ST_STOP:   state_d = ST_IDLE;
`endif
      default:   state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);

    // Line mux of the current state; registering it makes TX lag state by one.
    tx_d = LINE_IDLE;
    case (state_q)
      ST_START:  tx_d = START_BIT;
      ST_DATA:   tx_d = bus.SER_OUT;
      ST_PARITY: tx_d = par_bit_q;
      default:   tx_d = LINE_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      tx_q      <= LINE_IDLE;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      tx_q      <= tx_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end

  assign bus.SER_EN = (state_q == ST_DATA);
  assign bus.BUSY   = busy_q;
  assign bus.TX_OUT = tx_q;

endmodule
